gmii_rx_parser: RTL and testbench
=================================

Name: gmii_rx_parser

Overview:
Receive-side counterpart of the GMII transmitter. Parses Ethernet frames arriving on the PHY GMII receive bus, filters them by MAC, ethertype and stream id, and unpacks the payload. Video payload goes out as 48-bit words to the video FIFO, and AX (audio) payload as 12-bit words to the AX FIFO. Sits between the PHY and the receive FIFOs that feed the TMDS/HDMI output timing.

Parameters:
MAC_ADDR, 48'h0000_5E00_FACE, station address; dst must equal this or ff:ff:ff:ff:ff:ff
ETHERTYPE, 16'h88B5, accepted ethertype
TYPE_VIDEO, 8'h00, app-header type code for video frames
TYPE_AX, 8'h01, app-header type code for AX frames

Ports:
rx_clk  in  1  GMII receive clock, 125 MHz; sole clock
rstbtn_n  in  1  reset, synchronous, active-low
id  in  1  stream id; frame accepted only if app id byte[0] == id
rx_dv  in  1  GMII receive data valid
rx_er  in  1  GMII receive error
rxd  in  8  GMII receive data
v_din  out  48  video word to FIFO
v_wr_en  out  1  video FIFO write strobe
v_full  in  1  video FIFO full
a_din  out  12  AX word to FIFO
a_wr_en  out  1  AX FIFO write strobe
a_full  in  1  AX FIFO full
line_num  out  11  line number of the last accepted frame
frame_ok  out  1  one-cycle pulse: frame parsed completely
frame_drop  out  1  one-cycle pulse: frame discarded
ovf  out  1  sticky: a word was lost because the FIFO was full

Behaviour:
- All outputs and registers are sampled on the rx_clk rising edge. Inputs rx_dv/rx_er/rxd are registered once before the FSM.
- Reset (rstbtn_n=0): v_din=0, v_wr_en=0, a_din=0, a_wr_en=0, line_num=0, frame_ok=0, frame_drop=0, ovf=0, state=DROP.
  - Reset mid-frame: the remainder of that frame is ignored and no pulse is issued.
- Frame layout after SFD:
  - dst[6], src[6], ethertype[2] (big-endian)
  - app header[5]: id, type, line[10:8] (upper bits ignored), line[7:0], wcnt
  - payload: wcnt words
  - FCS[4]: ignored, not checked
- Word packing:
  - Video word = 6 bytes, first byte -> v_din[47:40].
  - AX word = 2 bytes, first byte low nibble -> a_din[11:8], second byte -> a_din[7:0].
- States:
  - IDLE: wait for rx_dv=1 with rxd=0x55 -> PRE. rx_dv=1 with any other byte -> DROP.
  - PRE: 0x55 stays. 0xD5 -> HDR with byte counter=0. Any other byte -> DROP.
  - HDR: 14 bytes. After byte 13: dst mismatch (not MAC_ADDR and not broadcast) or ethertype != ETHERTYPE -> DROP, else -> APP.
  - APP: 5 bytes. After byte 4: id bit mismatch, or type not TYPE_VIDEO/TYPE_AX -> DROP. wcnt=0 -> TAIL. Otherwise -> PAY.
  - PAY: bytes accumulate in a shift register. On the last byte of each word, the write strobe goes high in the next cycle for exactly one cycle. After wcnt words -> TAIL.
  - TAIL: wait for rx_dv=0. Then frame_ok pulses, line_num is updated, -> IDLE. The FCS count is not enforced.
  - DROP: wait for rx_dv=0. Then frame_drop pulses, -> IDLE. Exception: DROP entered from reset gives no pulse.
- Abort conditions:
  - rx_er=1 while rx_dv=1 in any state except IDLE/DROP -> DROP.
  - rx_dv=0 in PRE/HDR/APP/PAY -> frame_drop pulse next cycle, -> IDLE.
  - Words already written stay in the FIFO. A partial word is discarded.
- Full handling: if v_full (or a_full) is high in the cycle a strobe would assert, the strobe is suppressed and ovf is set. Parsing continues.
- Latency: last payload byte on rxd -> write strobe high 2 cycles later (1 input register + 1 output register).
- Back-to-back frames: a minimum 1-cycle rx_dv=0 gap is supported; IDLE accepts the next preamble on the following cycle.
- Byte counter is 3 bits; word counter is 8 bits and compared against wcnt, with no wrap beyond 255.

Decomposition:
- Package gmii_pkg holds:
  - state encoding (IDLE, PRE, HDR, APP, PAY, TAIL, DROP)
  - header lengths (14, 5)
  - preamble/SFD constants (0x55, 0xD5)
  - TYPE codes shared with gmii_tx
- One natural sub-module, gmii_rx_unpack: a shift register plus word/byte counters. It takes the byte stream, word size (6 or 2) and wcnt, and produces packed words with strobes. The FSM stays in the top level.

Test Plan:
- Video frame to MAC_ADDR, id=1, type 0, line 0x2A5, wcnt=2, payload 00..0B -> v_din=0x000102030405 then 0x060708090A0B, two single-cycle strobes, frame_ok, line_num=0x2A5.
- AX frame, wcnt=3, payload 0x1A,0xBC,0x02,0x34,0xF5,0x67 -> a_din=0xABC, 0x234, 0x567; high nibble of the first byte ignored.
- Ethertype 0x0800, or id byte 0x00 with id=1 -> no write strobes, frame_drop once, line_num unchanged.
- rx_dv drops after 8 of 12 video payload bytes -> exactly one v_wr_en, frame_drop; next good frame is accepted normally.
- v_full held high during the second word of a wcnt=2 frame -> one write only, ovf=1 stays set, frame_ok still pulses.
- rstbtn_n low for 1 cycle mid-payload -> no further writes and no pulse for that frame; the following frame after a 1-cycle gap gives frame_ok.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive path.
package gmii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        APP,
        PAY,
        TAIL,
        DROP
    } state_e;

    localparam int unsigned HDR_LEN = 14;   // dst + src + ethertype
    localparam int unsigned APP_LEN = 5;    // id, type, line hi, line lo, wcnt

    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD      = 8'hD5;

    // App-header type codes, shared with the transmitter
    localparam logic [7:0] PKT_TYPE_VIDEO = 8'h00;
    localparam logic [7:0] PKT_TYPE_AX    = 8'h01;

    // Byte idx (0 = first on the wire) of a big-endian 48-bit address
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] s;
        s = mac << (8 * idx);
        return s[47:40];
    endfunction

endpackage

// File: rtl/gmii_rx_unpack.sv
// Packs a payload byte stream into 6-byte video or 2-byte AX words.
module gmii_rx_unpack
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,      // new payload: clear counters, latch size/count
    input  logic        is_video,   // word size select, sampled with start
    input  logic [7:0]  wcnt,       // word count, sampled with start
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [47:0] word,
    output logic        word_wr,    // one-cycle strobe, word valid
    output logic        word_video, // size of the word being presented
    output logic        last        // byte_in completes the final word
);

    logic [39:0] sr_q, sr_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  widx_q, widx_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        vid_q, vid_d;
    logic [47:0] word_q, word_d;
    logic        wr_q, wr_d;
    logic        last_byte;

    assign last_byte  = (bcnt_q == (vid_q ? 3'd5 : 3'd1));
    assign last       = byte_vld && last_byte && ((widx_q + 8'd1) == wcnt_q);
    assign word       = word_q;
    assign word_wr    = wr_q;
    assign word_video = vid_q;

    // Shift bytes in; emit the assembled word on its last byte
    always_comb begin
        sr_d   = sr_q;
        bcnt_d = bcnt_q;
        widx_d = widx_q;
        wcnt_d = wcnt_q;
        vid_d  = vid_q;
        word_d = word_q;
        wr_d   = 1'b0;
        if (start) begin
            sr_d   = '0;
            bcnt_d = '0;
            widx_d = '0;
            wcnt_d = wcnt;
            vid_d  = is_video;
        end else if (byte_vld) begin
            if (last_byte) begin
                // AX keeps only the low nibble of its first byte
                word_d = vid_q ? {sr_q, byte_in} : {36'd0, sr_q[3:0], byte_in};
                wr_d   = 1'b1;
                bcnt_d = '0;
                widx_d = widx_q + 8'd1;
            end else begin
                sr_d   = {sr_q[31:0], byte_in};
                bcnt_d = bcnt_q + 3'd1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q   <= '0;
            bcnt_q <= '0;
            widx_q <= '0;
            wcnt_q <= '0;
            vid_q  <= 1'b0;
            word_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            bcnt_q <= bcnt_d;
            widx_q <= widx_d;
            wcnt_q <= wcnt_d;
            vid_q  <= vid_d;
            word_q <= word_d;
            wr_q   <= wr_d;
        end
    end

endmodule

// File: rtl/gmii_rx_parser.sv
// GMII receive frame parser: filters on MAC/ethertype/id, unpacks payload to FIFOs.
module gmii_rx_parser
    import gmii_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR   = 48'h0000_5E00_FACE,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter logic [7:0]  TYPE_VIDEO = PKT_TYPE_VIDEO,
    parameter logic [7:0]  TYPE_AX    = PKT_TYPE_AX
) (
    input  logic        rx_clk,
    input  logic        rstbtn_n,
    input  logic        id,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic [47:0] v_din,
    output logic        v_wr_en,
    input  logic        v_full,
    output logic [11:0] a_din,
    output logic        a_wr_en,
    input  logic        a_full,
    output logic [10:0] line_num,
    output logic        frame_ok,
    output logic        frame_drop,
    output logic        ovf
);

    logic        rx_dv_q, rx_er_q;
    logic [7:0]  rxd_q;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mac_ok_q, mac_ok_d, bc_ok_q, bc_ok_d, et_ok_q, et_ok_d, id_ok_q, id_ok_d;
    logic [7:0]  type_q, type_d;
    logic [10:0] line_pend_q, line_pend_d, line_num_q, line_num_d;
    logic        frame_ok_q, frame_ok_d, frame_drop_q, frame_drop_d;
    logic        nopulse_q, nopulse_d;  // DROP was entered from reset
    logic        ovf_q, ovf_d;
    logic        up_start, up_vld, up_last, up_wr, up_video;
    logic [47:0] up_word;

    gmii_rx_unpack u_unpack (
        .clk        (rx_clk),
        .rst_n      (rstbtn_n),
        .start      (up_start),
        .is_video   (type_q == TYPE_VIDEO),
        .wcnt       (rxd_q),
        .byte_vld   (up_vld),
        .byte_in    (rxd_q),
        .word       (up_word),
        .word_wr    (up_wr),
        .word_video (up_video),
        .last       (up_last)
    );

    // FIFO full is judged in the cycle the strobe is presented
    assign v_din      = up_word;
    assign a_din      = up_word[11:0];
    assign v_wr_en    = up_wr && up_video && !v_full;
    assign a_wr_en    = up_wr && !up_video && !a_full;
    assign line_num   = line_num_q;
    assign frame_ok   = frame_ok_q;
    assign frame_drop = frame_drop_q;
    assign ovf        = ovf_q;

    // Input capture; left out of reset so DROP sees the live rx_dv right after reset
    always_ff @(posedge rx_clk) begin
        rx_dv_q <= rx_dv;
        rx_er_q <= rx_er;
        rxd_q   <= rxd;
    end

    // Frame FSM next-state and header field capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mac_ok_d     = mac_ok_q;
        bc_ok_d      = bc_ok_q;
        et_ok_d      = et_ok_q;
        id_ok_d      = id_ok_q;
        type_d       = type_q;
        line_pend_d  = line_pend_q;
        line_num_d   = line_num_q;
        frame_ok_d   = 1'b0;
        frame_drop_d = 1'b0;
        nopulse_d    = nopulse_q;
        ovf_d        = ovf_q || (up_wr && (up_video ? v_full : a_full));
        up_start     = 1'b0;
        up_vld       = 1'b0;
        case (state_q)
            IDLE: if (rx_dv_q) state_d = (rxd_q == PREAMBLE) ? PRE : DROP;
            PRE, HDR, APP, PAY: begin
                if (!rx_dv_q) begin
                    frame_drop_d = 1'b1;
                    state_d      = IDLE;
                end else if (rx_er_q) begin
                    state_d = DROP;
                end else if (state_q == PRE) begin
                    if (rxd_q == SFD) begin
                        state_d  = HDR;
                        cnt_d    = '0;
                        mac_ok_d = 1'b1;
                        bc_ok_d  = 1'b1;
                        et_ok_d  = 1'b1;
                    end else if (rxd_q != PREAMBLE) begin
                        state_d = DROP;
                    end
                end else if (state_q == HDR) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q < 4'd6) begin
                        mac_ok_d = mac_ok_q && (rxd_q == mac_byte(MAC_ADDR, cnt_q[2:0]));
                        bc_ok_d  = bc_ok_q && (rxd_q == 8'hFF);
                    end
                    if (cnt_q == 4'd12) et_ok_d = (rxd_q == ETHERTYPE[15:8]);
                    if (cnt_q == 4'(HDR_LEN - 1)) begin
                        et_ok_d = et_ok_q && (rxd_q == ETHERTYPE[7:0]);
                        cnt_d   = '0;
                        state_d = ((mac_ok_q || bc_ok_q) && et_ok_d) ? APP : DROP;
                    end
                end else if (state_q == APP) begin
                    cnt_d = cnt_q + 4'd1;
                    case (cnt_q)
                        4'd0: id_ok_d = (rxd_q[0] == id);
                        4'd1: type_d = rxd_q;
                        4'd2: line_pend_d[10:8] = rxd_q[2:0];
                        4'd3: line_pend_d[7:0] = rxd_q;
                        default: begin
                            if (!id_ok_q || (type_q != TYPE_VIDEO && type_q != TYPE_AX))
                                state_d = DROP;
                            else if (rxd_q == 8'd0)
                                state_d = TAIL;
                            else begin
                                state_d  = PAY;
                                up_start = 1'b1;
                            end
                        end
                    endcase
                end else begin
                    up_vld = 1'b1;
                    if (up_last) state_d = TAIL;
                end
            end
            TAIL: begin
                if (!rx_dv_q) begin
                    frame_ok_d = 1'b1;
                    line_num_d = line_pend_q;
                    state_d    = IDLE;
                end else if (rx_er_q) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!rx_dv_q) begin
                    frame_drop_d = !nopulse_q;
                    nopulse_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = DROP;
        endcase
    end

    // FSM and status registers
    always_ff @(posedge rx_clk) begin
        if (!rstbtn_n) begin
            state_q      <= DROP;
            cnt_q        <= '0;
            mac_ok_q     <= 1'b0;
            bc_ok_q      <= 1'b0;
            et_ok_q      <= 1'b0;
            id_ok_q      <= 1'b0;
            type_q       <= '0;
            line_pend_q  <= '0;
            line_num_q   <= '0;
            frame_ok_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            nopulse_q    <= 1'b1;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mac_ok_q     <= mac_ok_d;
            bc_ok_q      <= bc_ok_d;
            et_ok_q      <= et_ok_d;
            id_ok_q      <= id_ok_d;
            type_q       <= type_d;
            line_pend_q  <= line_pend_d;
            line_num_q   <= line_num_d;
            frame_ok_q   <= frame_ok_d;
            frame_drop_q <= frame_drop_d;
            nopulse_q    <= nopulse_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_gmii_rx_parser.sv
// Scoreboard bench for gmii_rx_parser: expected words/events queued at stimulus time.
module tb_gmii_rx_parser;

    localparam logic [47:0] MAC = 48'h0000_5E00_FACE;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        rx_clk, rstbtn_n, id, rx_dv, rx_er, v_full, a_full;
    logic [7:0]  rxd;
    logic [47:0] v_din;
    logic [11:0] a_din;
    logic        v_wr_en, a_wr_en, frame_ok, frame_drop, ovf;
    logic [10:0] line_num;

    typedef struct {
        int          kind;   // 1 = frame_ok, 2 = frame_drop
        logic [10:0] line;
    } ev_t;

    logic [47:0] vq[$];
    logic [11:0] aq[$];
    ev_t         evq[$];
    logic [7:0]  frm[$];
    logic [7:0]  pay[$];
    logic [10:0] exp_line;
    int          checks = 0;
    int          failures = 0;

    gmii_rx_parser dut (
        .rx_clk(rx_clk), .rstbtn_n(rstbtn_n), .id(id), .rx_dv(rx_dv), .rx_er(rx_er),
        .rxd(rxd), .v_din(v_din), .v_wr_en(v_wr_en), .v_full(v_full), .a_din(a_din),
        .a_wr_en(a_wr_en), .a_full(a_full), .line_num(line_num), .frame_ok(frame_ok),
        .frame_drop(frame_drop), .ovf(ovf)
    );

    initial rx_clk = 1'b0;
    always #4 rx_clk = ~rx_clk;

    // Output monitor: every strobe/pulse must match the head of its queue
    always @(negedge rx_clk) begin
        if (v_wr_en) begin
            checks++;
            if (vq.size() == 0) begin
                failures++;
                $display("FAIL v_word unexpected strobe got=%h", v_din);
            end else begin
                logic [47:0] e;
                e = vq.pop_front();
                if (v_din !== e) begin
                    failures++;
                    $display("FAIL v_word got=%h exp=%h", v_din, e);
                end
            end
        end
        if (a_wr_en) begin
            checks++;
            if (aq.size() == 0) begin
                failures++;
                $display("FAIL a_word unexpected strobe got=%h", a_din);
            end else begin
                logic [11:0] e;
                e = aq.pop_front();
                if (a_din !== e) begin
                    failures++;
                    $display("FAIL a_word got=%h exp=%h", a_din, e);
                end
            end
        end
        if (frame_ok || frame_drop) begin
            checks++;
            if (evq.size() == 0) begin
                failures++;
                $display("FAIL event unexpected ok=%b drop=%b", frame_ok, frame_drop);
            end else begin
                ev_t e;
                e = evq.pop_front();
                if (e.kind == 1) exp_line = e.line;
                if ((frame_ok !== (e.kind == 1)) || (frame_drop !== (e.kind == 2)) ||
                    (line_num !== exp_line)) begin
                    failures++;
                    $display("FAIL event ok=%b drop=%b line=%h exp_kind=%0d exp_line=%h",
                             frame_ok, frame_drop, line_num, e.kind, exp_line);
                end
            end
        end
    end

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] idb,
                         input logic [7:0] typ, input logic [10:0] line, input logic [7:0] wcnt);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[8*(5-i) +: 8]);
        frm.push_back(8'h02); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h01);
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        frm.push_back(idb); frm.push_back(typ);
        frm.push_back({5'b10110, line[10:8]});   // junk upper bits must be ignored
        frm.push_back(line[7:0]); frm.push_back(wcnt);
        foreach (pay[i]) frm.push_back(pay[i]);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
    endtask

    task automatic set_pay(input logic [7:0] base, input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(base + 8'(i));
    endtask

    task automatic expect_words(input bit video, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            if (video) begin
                logic [47:0] x;
                x = '0;
                for (int b = 0; b < 6; b++) x = {x[39:0], pay[6*w+b]};
                vq.push_back(x);
            end else begin
                logic [7:0] b0;
                b0 = pay[2*w];
                aq.push_back({b0[3:0], pay[2*w+1]});
            end
        end
    endtask

    task automatic expect_ev(input int kind, input logic [10:0] line);
        ev_t e;
        e.kind = kind;
        e.line = line;
        evq.push_back(e);
    endtask

    // Send preamble+SFD then frm; cut<0 sends all. *_at index into frm (-1 = never).
    task automatic send(input int cut, input int full_at, input int rst_at, input int er_at, input int gap);
        int n;
        n = (cut < 0) ? frm.size() : cut;
        for (int i = 0; i < 8; i++) begin
            @(posedge rx_clk); #1;
            rx_dv = 1'b1; rx_er = 1'b0;
            rxd = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge rx_clk); #1;
            rxd = frm[i];
            rx_er = (i == er_at);
            if (i == full_at) v_full = 1'b1;
            rstbtn_n = (i == rst_at) ? 1'b0 : 1'b1;
        end
        @(posedge rx_clk); #1;
        rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00; rstbtn_n = 1'b1;
        for (int i = 1; i < gap; i++) @(posedge rx_clk);
        #1;
        v_full = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (vq.size() + aq.size() + evq.size()) > 0; i++) @(posedge rx_clk);
        repeat (4) @(posedge rx_clk);
        checks++;
        if ((vq.size() + aq.size() + evq.size()) != 0) begin
            failures++;
            $display("FAIL drain pending v=%0d a=%0d ev=%0d exp=0",
                     vq.size(), aq.size(), evq.size());
        end
    endtask

    task automatic test_reset();
        rstbtn_n = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        checks++;
        if ({v_wr_en, a_wr_en, frame_ok, frame_drop, ovf} !== 5'b0 || line_num !== 11'd0 ||
            v_din !== 48'd0 || a_din !== 12'd0) begin
            failures++;
            $display("FAIL reset strobes=%b line=%h v=%h a=%h exp=all zero",
                     {v_wr_en, a_wr_en, frame_ok, frame_drop, ovf}, line_num, v_din, a_din);
        end
        @(posedge rx_clk); #1;
        rstbtn_n = 1'b1;
        exp_line = '0;
        repeat (3) @(posedge rx_clk);
    endtask

    task automatic test_video();
        set_pay(8'h00, 12);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h2A5, 8'd2);
        expect_words(1'b1, 2);
        expect_ev(1, 11'h2A5);
        send(-1, -1, -1, -1, 3);
        drain();
        checks++;
        if (line_num !== 11'h2A5 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL video_line line=%h ovf=%b exp=2a5/0", line_num, ovf);
        end
    endtask

    task automatic test_ax();
        pay = '{8'h1A, 8'hBC, 8'h02, 8'h34, 8'hF5, 8'h67};
        build(BCAST, 16'h88B5, 8'h01, 8'h01, 11'h123, 8'd3);
        expect_words(1'b0, 3);
        expect_ev(1, 11'h123);
        send(-1, -1, -1, -1, 2);
        drain();
    endtask

    task automatic test_filter();
        set_pay(8'h40, 6);
        build(MAC, 16'h0800, 8'h01, 8'h00, 11'h111, 8'd1);
        expect_ev(2, 0); send(-1, -1, -1, -1, 2);
        build(MAC, 16'h88B5, 8'h00, 8'h00, 11'h222, 8'd1);
        expect_ev(2, 0); send(-1, -1, -1, -1, 2);
        build(MAC, 16'h88B5, 8'h01, 8'h02, 11'h333, 8'd1);
        expect_ev(2, 0); send(-1, -1, -1, -1, 2);
        build(MAC ^ 48'h1, 16'h88B5, 8'h01, 8'h00, 11'h444, 8'd1);
        expect_ev(2, 0); send(-1, -1, -1, -1, 2);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h555, 8'd1);
        expect_ev(2, 0); send(-1, -1, -1, 3, 2);   // rx_er in header
        // Non-preamble byte in IDLE
        expect_ev(2, 0);
        @(posedge rx_clk); #1; rx_dv = 1'b1; rxd = 8'h12;
        @(posedge rx_clk); #1; rx_dv = 1'b0; rxd = 8'h00;
        drain();
        checks++;
        if (line_num !== 11'h123) begin
            failures++;
            $display("FAIL filter_line line=%h exp=123", line_num);
        end
    endtask

    task automatic test_zero_wcnt();
        pay.delete();
        build(MAC, 16'h88B5, 8'h01, 8'h01, 11'h7FF, 8'd0);
        expect_ev(1, 11'h7FF);
        send(-1, -1, -1, -1, 2);
        drain();
    endtask

    task automatic test_abort();
        set_pay(8'h80, 12);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h0AA, 8'd2);
        expect_words(1'b1, 1);
        expect_ev(2, 0);
        send(19 + 8, -1, -1, -1, 1);
        set_pay(8'hC0, 12);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h0BB, 8'd2);
        expect_words(1'b1, 2);
        expect_ev(1, 11'h0BB);
        send(-1, -1, -1, -1, 2);
        drain();
    endtask

    task automatic test_full();
        set_pay(8'h10, 12);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h321, 8'd2);
        expect_words(1'b1, 1);
        expect_ev(1, 11'h321);
        send(-1, 19 + 8, -1, -1, 2);
        drain();
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=1", ovf);
        end
        set_pay(8'h50, 4);
        build(MAC, 16'h88B5, 8'h01, 8'h01, 11'h322, 8'd2);
        expect_words(1'b0, 2);
        expect_ev(1, 11'h322);
        send(-1, -1, -1, -1, 2);
        drain();
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=1", ovf);
        end
    endtask

    task automatic test_reset_mid();
        set_pay(8'h20, 12);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h1CC, 8'd2);
        expect_words(1'b1, 1);
        send(-1, -1, 19 + 8, -1, 1);
        exp_line = '0;
        checks++;
        if (line_num !== 11'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid line=%h ovf=%b exp=0/0", line_num, ovf);
        end
        pay = '{8'hF1, 8'h11, 8'h02, 8'h22};
        build(BCAST, 16'h88B5, 8'h01, 8'h01, 11'h1DD, 8'd2);
        expect_words(1'b0, 2);
        expect_ev(1, 11'h1DD);
        send(-1, -1, -1, -1, 2);
        drain();
    endtask

    task automatic test_back_to_back();
        set_pay(8'hA0, 6);
        build(MAC, 16'h88B5, 8'h01, 8'h00, 11'h001, 8'd1);
        expect_words(1'b1, 1); expect_ev(1, 11'h001);
        send(-1, -1, -1, -1, 1);
        set_pay(8'hB0, 6);
        build(BCAST, 16'h88B5, 8'h01, 8'h00, 11'h002, 8'd1);
        expect_words(1'b1, 1); expect_ev(1, 11'h002);
        send(-1, -1, -1, -1, 1);
        set_pay(8'hE0, 2);
        build(MAC, 16'h88B5, 8'h01, 8'h01, 11'h003, 8'd1);
        expect_words(1'b0, 1); expect_ev(1, 11'h003);
        send(-1, -1, -1, -1, 1);
        drain();
        checks++;
        if (line_num !== 11'h003) begin
            failures++;
            $display("FAIL b2b_line line=%h exp=003", line_num);
        end
    endtask

    initial begin
        rstbtn_n = 1'b0; id = 1'b1; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        v_full = 1'b0; a_full = 1'b0; exp_line = '0;
        test_reset();
        test_video();
        test_ax();
        test_filter();
        test_zero_wcnt();
        test_abort();
        test_full();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
